// File: rtl/snd_dma_pkg.sv
// Sound DMA controller shared types and constants.
// State encoding, register map and address byte packing.
package snd_dma_pkg;

  localparam int ADDR_W     = 21;
  localparam int FIFO_DEPTH = 4;

  localparam logic [3:0] SEL_CTRL = 4'd0;
  localparam logic [3:0] SEL_SH   = 4'd1;
  localparam logic [3:0] SEL_SM   = 4'd2;
  localparam logic [3:0] SEL_SL   = 4'd3;
  localparam logic [3:0] SEL_EH   = 4'd4;
  localparam logic [3:0] SEL_EM   = 4'd5;
  localparam logic [3:0] SEL_EL   = 4'd6;
  localparam logic [3:0] SEL_CH   = 4'd8;
  localparam logic [3:0] SEL_CM   = 4'd9;
  localparam logic [3:0] SEL_CL   = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_WAIT_ACK,
    S_ENDF
  } state_t;

  // Word address laid out as byte address bytes: 2=hi, 1=mid, 0=lo.
  function automatic logic [7:0] addr_byte(
    input logic [ADDR_W-1:0] a,
    input logic [1:0]        b
  );
    logic [7:0] r;
    r = 8'h00;
    case (b)
      2'd2:    r = {2'b00, a[20:15]};
      2'd1:    r = a[14:7];
      default: r = {a[6:0], 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snd_addr_cnt.sv
// Frame address counter: current and end word addresses.
// Loads both at frame start, increments per fetched word.
module snd_addr_cnt
  import snd_dma_pkg::*;
(
  input  logic              clk,
  input  logic              porb,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] start_w,
  input  logic [ADDR_W-1:0] end_w,
  output logic [ADDR_W-1:0] cur,
  output logic              at_end,
  output logic              next_end
);

  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] end_q;
  logic [ADDR_W-1:0] cur_inc;

  assign cur_inc  = cur_q + ADDR_W'(1);
  assign cur      = cur_q;
  assign at_end   = (cur_q == end_q);
  assign next_end = (cur_inc == end_q);

  // Working registers: frame load has priority over increment.
  always_ff @(posedge clk or negedge porb) begin
    if (!porb) begin
      cur_q <= '0;
      end_q <= '0;
    end else if (load) begin
      cur_q <= start_w;
      end_q <= end_w;
    end else if (inc) begin
      cur_q <= cur_inc;
    end
  end

endmodule

// File: rtl/snd_dma_ctrl.sv
// Sound DMA controller: fetches frame words into a 4-word FIFO.
// Register file, frame FSM and FIFO occupancy tracking.
module snd_dma_ctrl
  import snd_dma_pkg::*;
(
  input  logic              clk,
  input  logic              porb,
  input  logic              reg_we,
  input  logic [3:0]        reg_sel,
  input  logic [7:0]        reg_din,
  output logic [7:0]        reg_dout,
  input  logic              slot,
  input  logic              ack,
  input  logic              sample_tick,
  output logic              dma_req,
  output logic [ADDR_W-1:0] dma_addr,
  output logic              fifo_push,
  output logic [2:0]        fifo_level,
  output logic              sint,
  output logic              sndon
);

  state_t            state;
  state_t            state_nx;
  logic              enable;
  logic              rpt;
  logic              underrun;
  logic [ADDR_W-1:0] start_sh;
  logic [ADDR_W-1:0] end_sh;
  logic [ADDR_W-1:0] cur;
  logic [2:0]        level;
  logic              load;
  logic              push;
  logic              at_end;
  logic              next_end;
  logic              clr_en;
  logic              ctrl_wr;
  logic              en_wr;

  assign ctrl_wr    = reg_we && (reg_sel == SEL_CTRL);
  assign en_wr      = ctrl_wr ? reg_din[0] : enable;
  assign push       = (state == S_WAIT_ACK) && ack;
  assign fifo_push  = push;
  assign fifo_level = level;
  assign sndon      = enable;
  assign dma_addr   = dma_req ? cur : '0;

  snd_addr_cnt u_cnt (
    .clk      (clk),
    .porb     (porb),
    .load     (load),
    .inc      (push),
    .start_w  (start_sh),
    .end_w    (end_sh),
    .cur      (cur),
    .at_end   (at_end),
    .next_end (next_end)
  );

  // State register.
  always_ff @(posedge clk or negedge porb) begin
    if (!porb) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state and per-state strobes.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    dma_req  = 1'b0;
    sint     = 1'b0;
    clr_en   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (en_wr) state_nx = S_LOAD;
      end
      S_LOAD: begin
        load     = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN: begin
        if (!enable) begin
          state_nx = S_IDLE;
        end else if (at_end) begin
          state_nx = S_ENDF;
        end else if (slot && level < 3'(FIFO_DEPTH)) begin
          dma_req  = 1'b1;
          state_nx = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        dma_req = 1'b1;
        if (ack) begin
          if (!enable)      state_nx = S_IDLE;
          else if (next_end) state_nx = S_ENDF;
          else              state_nx = S_RUN;
        end
      end
      S_ENDF: begin
        sint = 1'b1;
        if (rpt && enable) begin
          state_nx = S_LOAD;
        end else begin
          clr_en   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Control bits; a bus write wins over the end-of-frame clear.
  always_ff @(posedge clk or negedge porb) begin
    if (!porb) begin
      enable <= 1'b0;
      rpt    <= 1'b0;
    end else if (ctrl_wr) begin
      enable <= reg_din[0];
      rpt    <= reg_din[1];
    end else if (clr_en) begin
      enable <= 1'b0;
    end
  end

  // Shadow start/end registers, picked up at the next frame load.
  always_ff @(posedge clk or negedge porb) begin
    if (!porb) begin
      start_sh <= '0;
      end_sh   <= '0;
    end else if (reg_we) begin
      case (reg_sel)
        SEL_SH:  start_sh[20:15] <= reg_din[5:0];
        SEL_SM:  start_sh[14:7]  <= reg_din;
        SEL_SL:  start_sh[6:0]   <= reg_din[7:1];
        SEL_EH:  end_sh[20:15]   <= reg_din[5:0];
        SEL_EM:  end_sh[14:7]    <= reg_din;
        SEL_EL:  end_sh[6:0]     <= reg_din[7:1];
        default: ;
      endcase
    end
  end

  // FIFO occupancy; a tick on an empty FIFO is dropped.
  always_ff @(posedge clk or negedge porb) begin
    if (!porb) begin
      level <= '0;
    end else if (push && !sample_tick) begin
      level <= level + 3'd1;
    end else if (!push && sample_tick && level != 3'd0) begin
      level <= level - 3'd1;
    end
  end

  // Sticky underrun; a new underrun beats a clearing ctrl write.
  always_ff @(posedge clk or negedge porb) begin
    if (!porb) begin
      underrun <= 1'b0;
    end else if (sample_tick && !push && level == 3'd0) begin
      underrun <= 1'b1;
    end else if (ctrl_wr) begin
      underrun <= 1'b0;
    end
  end

  // Register read mux.
  always_comb begin
    reg_dout = 8'h00;
    case (reg_sel)
      SEL_CTRL: reg_dout = {underrun, (state != S_IDLE),
                            4'b0000, rpt, enable};
      SEL_SH:   reg_dout = addr_byte(start_sh, 2'd2);
      SEL_SM:   reg_dout = addr_byte(start_sh, 2'd1);
      SEL_SL:   reg_dout = addr_byte(start_sh, 2'd0);
      SEL_EH:   reg_dout = addr_byte(end_sh, 2'd2);
      SEL_EM:   reg_dout = addr_byte(end_sh, 2'd1);
      SEL_EL:   reg_dout = addr_byte(end_sh, 2'd0);
      SEL_CH:   reg_dout = addr_byte(cur, 2'd2);
      SEL_CM:   reg_dout = addr_byte(cur, 2'd1);
      SEL_CL:   reg_dout = addr_byte(cur, 2'd0);
      default:  reg_dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_snd_dma_ctrl.sv
// Bench for snd_dma_ctrl: register table, frame sequences,
// and randomized frames against a word-list/occupancy model.
module tb_snd_dma_ctrl;

  logic        clk = 1'b0;
  logic        porb;
  logic        reg_we;
  logic [3:0]  reg_sel;
  logic [7:0]  reg_din;
  logic [7:0]  reg_dout;
  logic        slot;
  logic        ack;
  logic        sample_tick;
  logic        dma_req;
  logic [20:0] dma_addr;
  logic        fifo_push;
  logic [2:0]  fifo_level;
  logic        sint;
  logic        sndon;

  snd_dma_ctrl dut (
    .clk         (clk),
    .porb        (porb),
    .reg_we      (reg_we),
    .reg_sel     (reg_sel),
    .reg_din     (reg_din),
    .reg_dout    (reg_dout),
    .slot        (slot),
    .ack         (ack),
    .sample_tick (sample_tick),
    .dma_req     (dma_req),
    .dma_addr    (dma_addr),
    .fifo_push   (fifo_push),
    .fifo_level  (fifo_level),
    .sint        (sint),
    .sndon       (sndon)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] sel;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [20:0] got[$];
  int          sint_at[$];
  int          level_m;
  bit          underrun_m;
  bit          bus_on, ack_force, slot_rand, rnd_dly, chk2;
  int          dly, req_cnt, tick_mode, tick_ctr;
  logic        prev_req, prev_ack, req_s, sint_s;
  logic [20:0] prev_addr;
  logic [7:0]  dout_s;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, update model.
  task automatic cyc();
    bit tk;
    bit set_u;
    ack = ack_force ||
          (bus_on && req_cnt != 0 && req_cnt >= dly);
    case (tick_mode)
      1: tk = ($urandom_range(0, 5) == 0);
      2: tk = (tick_ctr % 8 == 7);
      3: tk = ack && (level_m == 2);
      4: begin tk = 1'b1; tick_mode = 0; end
      default: tk = 1'b0;
    endcase
    tick_ctr++;
    sample_tick = tk;
    slot = slot_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    dout_s = reg_dout;
    req_s  = dma_req;
    sint_s = sint;
    if (chk2) begin
      chk("coincide_level", fifo_level, 2);
      chk2 = 1'b0;
    end
    if (porb) begin
      chk("level", fifo_level, level_m);
      if (!reg_we && reg_sel == 4'd0)
        chk("underrun_bit", dout_s[7], underrun_m);
      if (prev_req && !prev_ack) begin
        chk("req_hold", dma_req, 1);
        chk("addr_hold", dma_addr, prev_addr);
      end
      if (fifo_push) begin
        got.push_back(dma_addr);
        chk("push_needs_ack", ack, 1);
        chk("push_room", level_m < 4, 1);
      end
      if (sint) sint_at.push_back(got.size());
      if (tick_mode == 3 && fifo_push && tk && level_m == 2) begin
        chk2 = 1'b1;
        tick_mode = 0;
      end
      set_u = tk && !fifo_push && level_m == 0;
      if (set_u) underrun_m = 1'b1;
      else if (reg_we && reg_sel == 4'd0) underrun_m = 1'b0;
      if (fifo_push && !tk) level_m++;
      else if (!fifo_push && tk && level_m > 0) level_m--;
    end
    prev_req  = dma_req;
    prev_ack  = ack;
    prev_addr = dma_addr;
    if (ack) begin
      req_cnt = 0;
      if (rnd_dly) dly = $urandom_range(1, 4);
    end else if (dma_req) begin
      req_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    porb = 1'b0; reg_we = 1'b0; reg_sel = 4'd0; reg_din = 8'h00;
    bus_on = 1'b0; ack_force = 1'b0; tick_mode = 0;
    slot_rand = 1'b0;
    cyc();
    cyc();
    porb = 1'b1;
    level_m = 0; underrun_m = 1'b0;
    got.delete(); sint_at.delete();
    prev_req = 1'b0; prev_ack = 1'b0; req_cnt = 0;
    chk2 = 1'b0; dly = 2; rnd_dly = 1'b0;
    cyc();
  endtask

  task automatic wr(input logic [3:0] s, input logic [7:0] d);
    reg_we = 1'b1; reg_sel = s; reg_din = d;
    cyc();
    reg_we = 1'b0; reg_sel = 4'd0; reg_din = 8'h00;
  endtask

  task automatic rd(input logic [3:0] s, output logic [7:0] d);
    reg_sel = s;
    cyc();
    d = dout_s;
    reg_sel = 4'd0;
  endtask

  task automatic set_frame(input logic [20:0] st,
                           input logic [20:0] en);
    wr(4'd1, {2'b00, st[20:15]});
    wr(4'd2, st[14:7]);
    wr(4'd3, {st[6:0], 1'($urandom_range(0, 1))});
    wr(4'd4, {2'b00, en[20:15]});
    wr(4'd5, en[14:7]);
    wr(4'd6, {en[6:0], 1'($urandom_range(0, 1))});
  endtask

  task automatic run_until_idle(input int lim);
    bit done;
    done = 1'b0;
    for (int n = 0; n < lim && !done; n++) begin
      cyc();
      if (!dout_s[6]) done = 1'b1;
    end
    chk("frame_timeout", done, 1);
  endtask

  task automatic chk_seq(input string nm, input logic [20:0] base,
                         input int n, input int modn);
    int errs;
    logic [20:0] e;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      e = base + 21'(i % modn);
      if (i >= got.size() || got[i] != e) errs++;
    end
    chk(nm, errs, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[13];
    logic [7:0]  d;
    logic [20:0] st;
    int          len, errs;
    bit          hit;

    vt[0]  = '{1'b1, 4'd1,  8'hFF, 8'h3F};
    vt[1]  = '{1'b1, 4'd2,  8'hA5, 8'hA5};
    vt[2]  = '{1'b1, 4'd3,  8'hFF, 8'hFE};
    vt[3]  = '{1'b1, 4'd4,  8'hC1, 8'h01};
    vt[4]  = '{1'b1, 4'd5,  8'h5A, 8'h5A};
    vt[5]  = '{1'b1, 4'd6,  8'h03, 8'h02};
    vt[6]  = '{1'b1, 4'd0,  8'h02, 8'h02};
    vt[7]  = '{1'b1, 4'd7,  8'hFF, 8'h00};
    vt[8]  = '{1'b0, 4'd8,  8'h00, 8'h00};
    vt[9]  = '{1'b0, 4'd9,  8'h00, 8'h00};
    vt[10] = '{1'b0, 4'd10, 8'h00, 8'h00};
    vt[11] = '{1'b0, 4'd11, 8'h00, 8'h00};
    vt[12] = '{1'b0, 4'd15, 8'h00, 8'h00};

    porb = 1'b0; reg_we = 1'b0; reg_sel = 4'd0; reg_din = 8'h00;
    slot = 1'b0; ack = 1'b0; sample_tick = 1'b0; tick_ctr = 0;
    bus_on = 1'b0; ack_force = 1'b0; tick_mode = 0;
    slot_rand = 1'b0; rnd_dly = 1'b0; chk2 = 1'b0;
    dly = 2; req_cnt = 0; level_m = 0; underrun_m = 1'b0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    @(negedge clk);

    do_reset();
    #1;
    chk("rst_req", dma_req, 0);
    chk("rst_addr", dma_addr, 0);
    chk("rst_push", fifo_push, 0);
    chk("rst_sint", sint, 0);
    chk("rst_sndon", sndon, 0);
    chk("rst_level", fifo_level, 0);
    @(negedge clk);
    rd(4'd0, d);
    chk("rst_status", d, 8'h00);

    foreach (vt[i]) begin
      if (vt[i].we) wr(vt[i].sel, vt[i].din);
      rd(vt[i].sel, d);
      chk($sformatf("reg_sel%0d", vt[i].sel), d, vt[i].exp);
    end

    // Single frame, no repeat, FIFO fills to 4.
    do_reset();
    set_frame(21'h100, 21'h104);
    bus_on = 1'b1;
    wr(4'd0, 8'h01);
    run_until_idle(100);
    repeat (10) cyc();
    chk("t1_count", got.size(), 4);
    chk_seq("t1_addrs", 21'h100, 4, 4);
    chk("t1_level", fifo_level, 4);
    chk("t1_sint_n", sint_at.size(), 1);
    if (sint_at.size() == 1) chk("t1_sint_at", sint_at[0], 4);
    rd(4'd0, d);
    chk("t1_status", d, 8'h00);
    rd(4'd8, d);  chk("t1_cur_hi", d, 8'h00);
    rd(4'd9, d);  chk("t1_cur_mid", d, 8'h02);
    rd(4'd10, d); chk("t1_cur_lo", d, 8'h08);

    // Repeating frame, DAC drains one word every 8 clocks.
    do_reset();
    set_frame(21'h100, 21'h104);
    bus_on = 1'b1; tick_mode = 2; tick_ctr = 0;
    wr(4'd0, 8'h03);
    repeat (300) cyc();
    rd(4'd0, d);
    chk("t2_underrun", d[7], 0);
    chk("t2_active", d[6], 1);
    wr(4'd0, 8'h00);
    repeat (30) cyc();
    tick_mode = 0;
    chk("t2_enough", got.size() >= 8, 1);
    chk_seq("t2_addrs", 21'h100, got.size(), 4);
    chk("t2_sints", sint_at.size() >= 2, 1);
    errs = 0;
    foreach (sint_at[i]) if (sint_at[i] != 4 * (i + 1)) errs++;
    chk("t2_sint_per_frame", errs, 0);

    // Empty frame: LOAD, RUN, ENDF, sint on the third clock.
    do_reset();
    set_frame(21'h2000, 21'h2000);
    bus_on = 1'b1;
    wr(4'd0, 8'h01);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk($sformatf("t3_sint_clk%0d", k), sint_s, k == 3);
      chk($sformatf("t3_req_clk%0d", k), req_s, 0);
    end
    rd(4'd0, d);
    chk("t3_status", d, 8'h00);

    // Push and tick in the same clock at level 2.
    do_reset();
    set_frame(21'h300, 21'h304);
    bus_on = 1'b1; tick_mode = 3;
    wr(4'd0, 8'h01);
    repeat (40) cyc();
    chk("t4_coincide_seen", tick_mode, 0);
    chk("t4_count", got.size(), 4);
    chk("t4_level", fifo_level, 3);

    // Tick on an empty FIFO sets sticky underrun.
    do_reset();
    tick_mode = 4;
    cyc();
    rd(4'd0, d);
    chk("t4_underrun_set", d, 8'h80);
    chk("t4_level0", fifo_level, 0);
    wr(4'd0, 8'h00);
    rd(4'd0, d);
    chk("t4_underrun_clr", d, 8'h00);

    // Disable while a request is outstanding.
    do_reset();
    set_frame(21'h400, 21'h408);
    bus_on = 1'b1; dly = 3;
    wr(4'd0, 8'h01);
    hit = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      cyc();
      if (got.size() == 1 && req_s) hit = 1'b1;
    end
    chk("t5_second_req", hit, 1);
    wr(4'd0, 8'h00);
    chk("t5_req_at_clear", req_s, 1);
    repeat (20) cyc();
    chk("t5_count", got.size(), 2);
    chk_seq("t5_addrs", 21'h400, 2, 2);
    chk("t5_no_sint", sint_at.size(), 0);
    rd(4'd0, d);
    chk("t5_status", d, 8'h00);

    // Shadow rewrite mid-frame applies to the next frame.
    do_reset();
    set_frame(21'h500, 21'h502);
    bus_on = 1'b1;
    wr(4'd0, 8'h03);
    for (int n = 0; n < 50 && got.size() < 1; n++) cyc();
    wr(4'd2, 8'h0C);
    wr(4'd5, 8'h0C);
    for (int n = 0; n < 100 && got.size() < 4; n++) cyc();
    wr(4'd0, 8'h00);
    repeat (20) cyc();
    chk("t5b_count", got.size() >= 4, 1);
    chk_seq("t5b_old", 21'h500, 2, 2);
    if (got.size() >= 4) begin
      chk("t5b_new0", got[2], 21'h600);
      chk("t5b_new1", got[3], 21'h601);
    end

    // Reset in WAIT_ACK; a late ack must not push.
    do_reset();
    set_frame(21'h700, 21'h708);
    bus_on = 1'b0;
    wr(4'd0, 8'h01);
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      cyc();
      if (req_s) hit = 1'b1;
    end
    chk("t6_req_seen", hit, 1);
    chk("t6_req_pre", dma_req, 1);
    #2 porb = 1'b0;
    #1;
    chk("t6_req", dma_req, 0);
    chk("t6_addr", dma_addr, 0);
    chk("t6_push", fifo_push, 0);
    chk("t6_sint", sint, 0);
    chk("t6_sndon", sndon, 0);
    chk("t6_level", fifo_level, 0);
    @(negedge clk);
    porb = 1'b1;
    prev_req = 1'b0; req_cnt = 0; level_m = 0; underrun_m = 1'b0;
    got.delete(); sint_at.delete();
    cyc();
    ack_force = 1'b1;
    cyc();
    ack_force = 1'b0;
    repeat (3) cyc();
    chk("t6_no_push", got.size(), 0);
    chk("t6_level_after", fifo_level, 0);
    rd(4'd0, d);
    chk("t6_status", d, 8'h00);

    // Randomized frames, including ones that wrap the address.
    do_reset();
    rnd_dly = 1'b1; slot_rand = 1'b1; bus_on = 1'b1; tick_mode = 1;
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 1) == 1)
        st = 21'h1FFFFF - 21'($urandom_range(0, 4));
      else
        st = 21'($urandom);
      len = $urandom_range(0, 6);
      got.delete();
      sint_at.delete();
      set_frame(st, st + 21'(len));
      wr(4'd0, 8'h01);
      run_until_idle(600);
      repeat (2) cyc();
      chk($sformatf("rnd%0d_count", f), got.size(), len);
      chk_seq($sformatf("rnd%0d_addrs", f), st, len, 64);
      chk($sformatf("rnd%0d_sint_n", f), sint_at.size(), 1);
      if (sint_at.size() == 1)
        chk($sformatf("rnd%0d_sint_at", f), sint_at[0], len);
      rd(4'd0, d);
      chk($sformatf("rnd%0d_enable", f), d[0], 0);
    end
    tick_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
